// File: rtl/hilo_div_seq_pkg.sv
// Shared definitions for the HI/LO divide sequencer: state encodings,
// handshake levels and the legacy word constants.
package hilo_div_seq_pkg;

  localparam int RegBus = 32;
  localparam logic [RegBus-1:0] ZeroWord = '0;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/hilo_div_seq_step.sv
// One restoring-division step: shift {rem, dvd} left by one, trial-subtract
// the divisor and shift the resulting quotient bit into the low half.
module hilo_div_seq_step
  import hilo_div_seq_pkg::*;
#(
  parameter int DATA_W = RegBus
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] dvd_i,
  input  logic [DATA_W-1:0] dsr_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] dvd_o
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] trial;

  // rem < dsr always holds, so the trial fits in DATA_W+1 bits and its MSB is the sign.
  assign shifted = {rem_i, dvd_i[DATA_W-1]};
  assign trial   = shifted - {1'b0, dsr_i};
  assign rem_o   = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
  assign dvd_o   = {dvd_i[DATA_W-2:0], ~trial[DATA_W]};

endmodule

// File: rtl/hilo_div_seq.sv
// Multi-cycle restoring divider for the HI/LO path: signed/unsigned 32-step
// division producing {remainder, quotient}, with stall request and annul.
module hilo_div_seq
  import hilo_div_seq_pkg::*;
#(
  parameter int DATA_W = RegBus
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic                  annul_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  function automatic logic [DATA_W-1:0] twos_neg(input logic [DATA_W-1:0] v);
    return ~v + 1'b1;
  endfunction

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_W-1:0]     rem_q, rem_d;
  logic [DATA_W-1:0]     dvd_q, dvd_d;
  logic [DATA_W-1:0]     dsr_q, dsr_d;
  logic                  qsign_q, qsign_d;
  logic                  rsign_q, rsign_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;

  logic                  op1_neg, op2_neg;
  logic [DATA_W-1:0]     step_rem, step_dvd;

  assign op1_neg = signed_i & opdata1_i[DATA_W-1];
  assign op2_neg = signed_i & opdata2_i[DATA_W-1];

  hilo_div_seq_step #(.DATA_W(DATA_W)) u_step (
    .rem_i (rem_q),
    .dvd_i (dvd_q),
    .dsr_i (dsr_q),
    .rem_o (step_rem),
    .dvd_o (step_dvd)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    result_d = result_q;
    ready_d  = ready_q;

    case (state_q)
      DivFree: begin
        ready_d  = DivResultNotReady;
        result_d = '0;
        if (start_i == DivStart && !annul_i) begin
          dvd_d   = op1_neg ? twos_neg(opdata1_i) : opdata1_i;
          dsr_d   = op2_neg ? twos_neg(opdata2_i) : opdata2_i;
          rem_d   = '0;
          qsign_d = op1_neg ^ op2_neg;
          rsign_d = op1_neg;
          count_d = '0;
          state_d = (opdata2_i == '0) ? DivByZero : DivOn;
        end
      end

      DivByZero: begin
        result_d = '0;
        if (annul_i) begin
          ready_d = DivResultNotReady;
          state_d = DivFree;
        end else begin
          ready_d = DivResultReady;
          state_d = DivEnd;
        end
      end

      DivOn: begin
        if (annul_i) begin
          result_d = '0;
          count_d  = '0;
          state_d  = DivFree;
        end else if (count_q != CNT_LAST) begin
          rem_d   = step_rem;
          dvd_d   = step_dvd;
          count_d = count_q + 1'b1;
        end else begin
          // Magnitudes are done; restore signs (remainder follows the dividend).
          result_d = {rsign_q ? twos_neg(rem_q) : rem_q,
                      qsign_q ? twos_neg(dvd_q) : dvd_q};
          ready_d  = DivResultReady;
          state_d  = DivEnd;
        end
      end

      DivEnd: begin
        if (annul_i || start_i == DivStop) begin
          ready_d  = DivResultNotReady;
          result_d = '0;
          state_d  = DivFree;
        end
      end

      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DivFree;
      count_q  <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      result_q <= '0;
      ready_q  <= DivResultNotReady;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = start_i & ~ready_q & ~annul_i;

endmodule

// File: doc/hilo_div_seq.md
Name: hilo_div_seq

Overview:
Multi-cycle divide sequencer for the HI/LO resource. Accepts DIV/DIVU operands from the execute stage and runs a 32-step restoring division, one quotient bit per cycle. Holds the execute stage via a stall request while busy. Presents {remainder, quotient} for the HI/LO write that travels down to the HI/LO register through mem_wb.

Parameters:
DATA_W, 32, operand width; the count width is clog2(DATA_W)+1.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, asynchronous, active-low
start_i  in  1  divide request from execute; held high until ready_o is seen
signed_i  in  1  1 = DIV (signed), 0 = DIVU; sampled at acceptance
annul_i  in  1  cancel (pipeline flush/exception); aborts any operation
opdata1_i  in  DATA_W  dividend; sampled at acceptance
opdata2_i  in  DATA_W  divisor; sampled at acceptance
result_o  out  2*DATA_W  {remainder (HI), quotient (LO)}
ready_o  out  1  result valid
stallreq_o  out  1  combinational: high while start_i && !ready_o && !annul_i

Behaviour:
Reset (rst low, asynchronous):
- state=FREE, result_o=0, ready_o=0, count=0, internal operand registers=0.
- Reset mid-operation aborts the operation immediately, with no partial result.

States: FREE, BYZERO, ON, END.

FREE:
- ready_o=0, result_o=0.
- Acceptance requires start_i=1 and annul_i=0.
  - If opdata2_i==0, go to BYZERO.
  - Otherwise go to ON with count=0.
- Latch operands:
  - If signed_i=1, latch the absolute values of both operands (two's-complement negate when the MSB is set).
  - Latch the quotient sign (op1 MSB XOR op2 MSB) and the remainder sign (op1 MSB). Both signs are 0 when unsigned.
- Working register: dividend in the low half, partial remainder = 0.

BYZERO:
- On the next edge, go to END with result_o=0.

ON:
- If annul_i=1: go to FREE, result_o=0, count=0.
- Else, while count<DATA_W, perform one step per edge:
  - Shift {rem, dvd} left by 1.
  - Trial = rem - divisor (DATA_W+1 bits).
  - If the trial is non-negative, rem=trial and the quotient LSB=1; else the quotient LSB=0.
  - count++.
- When count==DATA_W:
  - Apply signs: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - Load result_o, set ready_o=1, go to END.

END:
- ready_o=1 and result_o stable.
- If start_i==0, go to FREE (ready_o=0, result_o=0).
- If start_i is still high, stay in END; the result is held.

annul_i:
- In FREE, BYZERO or END, annul_i forces FREE on the next edge with result_o=0 and ready_o=0.
- annul_i overrides start_i.

Latency, counting the accepting edge as edge 1:
- Normal: ready_o rises after edge 34 (1 accept + 32 steps + 1 finalize).
- Divide by zero: ready_o rises after edge 2.

Arithmetic:
- Signed overflow 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. This falls out of unsigned magnitude arithmetic; no trap.
- Remainder takes the dividend's sign; quotient truncates toward zero.

Operand stability:
- Operand changes after acceptance have no effect.
- New operands are not accepted until the sequencer returns to FREE.

Decomposition:
Shared defines file holds:
- State encodings: DivFree, DivByZero, DivOn, DivEnd (2 bits).
- DivResultReady and DivResultNotReady.
- DivStart and DivStop.
- The existing ZeroWord and RegBus macros.

One optional combinational sub-module, hilo_div_step (shift plus trial subtract for a single step), keeps the FSM readable. Everything else stays inline.

Test Plan:
- DIVU 100/7, start held until ready -> ready_o after edge 34, result_o=0x00000002_0000000E; stallreq_o high from acceptance until ready_o rises.
- DIV -7/2 (0xFFFFFFF9, 0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD (rem -1, quot -3).
- DIV 0x80000000/0xFFFFFFFF -> result_o=0x00000000_80000000. DIVU 0xFFFFFFFF/1 -> result_o=0x00000000_FFFFFFFF.
- Divisor 0 (either mode) -> ready_o after edge 2, result_o=0; start held 5 more cycles -> stays END; start dropped -> FREE next edge.
- annul_i pulsed at edge 10 of an ON operation -> FREE, ready_o never rises, result_o=0. An immediate new start is accepted and completes correctly.
- rst driven low asynchronously (between edges) during ON -> outputs reach 0 immediately, not at the next edge. After release, a fresh 100/7 completes in 34 edges.
